// File: rtl/zbb_encoder.sv
// Zbb instruction encoder: op/rd/rs1/rs2 in, 32-bit RV32 word plus word address out via a FIFO.
// Optional combinational empty-FIFO bypass when ZBB_ENC_BYPASS_EN is defined.
module zbb_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_op,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err_illegal
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic [6:0] OpcR = 7'b0110011;
  localparam logic [6:0] OpcI = 7'b0010011;

  logic [31:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [LvlW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        legal;
  logic        empty, full;
  logic        accept, push_req, push, pop, out_fire;

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (in_op)
      4'd0:    enc_word = {7'b0100000, in_rs2, in_rs1, 3'b111, in_rd, OpcR};
      4'd1:    enc_word = {7'b0100000, in_rs2, in_rs1, 3'b110, in_rd, OpcR};
      4'd2:    enc_word = {7'b0100000, in_rs2, in_rs1, 3'b100, in_rd, OpcR};
      4'd3:    enc_word = {12'h600, in_rs1, 3'b001, in_rd, OpcI};
      4'd4:    enc_word = {12'h601, in_rs1, 3'b001, in_rd, OpcI};
      4'd5:    enc_word = {12'h602, in_rs1, 3'b001, in_rd, OpcI};
      4'd6:    enc_word = {7'b0000101, in_rs2, in_rs1, 3'b110, in_rd, OpcR};
      4'd7:    enc_word = {7'b0000101, in_rs2, in_rs1, 3'b111, in_rd, OpcR};
      4'd8:    enc_word = {7'b0000101, in_rs2, in_rs1, 3'b100, in_rd, OpcR};
      4'd9:    enc_word = {7'b0000101, in_rs2, in_rs1, 3'b101, in_rd, OpcR};
      4'd10:   enc_word = {12'h604, in_rs1, 3'b001, in_rd, OpcI};
      4'd11:   enc_word = {12'h605, in_rs1, 3'b001, in_rd, OpcI};
      default: legal    = 1'b0;
    endcase
  end

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == LvlW'(DEPTH));
  assign in_ready = !full && !clr;
  assign accept   = in_valid && in_ready;
  assign push_req = accept && legal;

`ifdef ZBB_ENC_BYPASS_EN
  logic bypass;
  assign bypass    = push_req && empty;
  assign out_valid = !empty || bypass;
  assign out_instr = empty ? enc_word : mem_q[rd_q];
  // A bypassed word taken in the same cycle never touches the FIFO.
  assign push      = push_req && !(bypass && out_ready);
  assign pop       = !empty && out_ready;
`else
  assign out_valid = !empty;
  assign out_instr = mem_q[rd_q];
  assign push      = push_req;
  assign pop       = out_valid && out_ready;
`endif

  assign out_fire    = out_valid && out_ready;
  assign out_addr    = addr_q;
  assign level       = cnt_q;
  assign err_illegal = err_q;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    err_d  = 1'b0;
    if (clr) begin
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      addr_d = ADDR_W'(BASE_ADDR);
    end else begin
      if (push) wr_d = wr_q + PtrW'(1);
      if (pop)  rd_d = rd_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + LvlW'(1);
        2'b01:   cnt_d = cnt_q - LvlW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (out_fire) addr_d = addr_q + ADDR_W'(1);
      err_d = accept && !legal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      addr_q <= ADDR_W'(BASE_ADDR);
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  // Storage needs no reset: contents are only observed behind a nonzero count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= enc_word;
  end

endmodule

// File: tb/tb_zbb_encoder.sv
// Self-checking bench for zbb_encoder: directed test-plan steps then random traffic,
// compared each cycle against a queue-based reference model.
module tb_zbb_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready2;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic        out_valid, out_valid2;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_instr2;
  logic [7:0]  out_addr;
  logic [1:0]  out_addr2;
  logic [2:0]  level, level2;
  logic        err_illegal, err_illegal2;

  always #5 clk = ~clk;

  zbb_encoder #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .level(level), .err_illegal(err_illegal)
  );

  // Narrow address counter instance to exercise wrap-around.
  zbb_encoder #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .level(level2), .err_illegal(err_illegal2)
  );

  int total = 0;
  int bad = 0;

  // Reference tables indexed by op code; imm == 0 marks an R-type op.
  int unsigned f7_tab[12]  = '{32, 32, 32, 0, 0, 0, 5, 5, 5, 5, 0, 0};
  int unsigned f3_tab[12]  = '{7, 6, 4, 1, 1, 1, 6, 7, 4, 5, 1, 1};
  int unsigned imm_tab[12] = '{0, 0, 0, 'h600, 'h601, 'h602, 0, 0, 0, 0, 'h604, 'h605};

  logic [31:0] mq[$];
  int unsigned m_addr = 0;
  logic        m_err = 1'b0;

  function automatic logic [31:0] ref_word(int unsigned op, int unsigned rd, int unsigned rs1,
                                           int unsigned rs2);
    int unsigned w;
    if (imm_tab[op] != 0)
      w = (imm_tab[op] << 20) + (rs1 << 15) + (1 << 12) + (rd << 7) + 'h13;
    else
      w = (f7_tab[op] << 25) + (rs2 << 20) + (rs1 << 15) + (f3_tab[op] << 12) + (rd << 7) + 'h33;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", {31'b0, in_ready}, {31'b0, (mq.size() < DEPTH) && !clr});
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    chk("level", {29'b0, level}, mq.size());
    chk("err_illegal", {31'b0, err_illegal}, {31'b0, m_err});
    chk("out_addr", {24'b0, out_addr}, m_addr % 256);
    chk("out_addr_w2", {30'b0, out_addr2}, m_addr % 4);
    if (mq.size() != 0) chk("out_instr", out_instr, mq[0]);
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int n;
    logic acc, pp;
    n   = mq.size();
    acc = in_valid && (n < DEPTH) && !clr;
    pp  = (n > 0) && out_ready;
    if (clr) begin
      mq.delete();
      m_addr = 0;
      m_err  = 1'b0;
    end else begin
      if (pp) begin
        void'(mq.pop_front());
        m_addr++;
      end
      if (acc && in_op < 12) mq.push_back(ref_word(in_op, in_rd, in_rs1, in_rs2));
      m_err = acc && (in_op >= 12);
    end
  endtask

  // Called at posedge+1: drive, check the pre-edge state, clock, update model.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic ordy,
                       input logic c);
    in_valid  = v;
    in_op     = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    out_ready = ordy;
    clr       = c;
    #1;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, ordy, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", {29'b0, level}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_addr", {24'b0, out_addr}, 0);
    chk("rst_err", {31'b0, err_illegal}, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 1);

    // andn, held, then taken
    cycle(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    chk("andn_word", out_instr, 32'h4020F1B3);
    chk("andn_addr", {24'b0, out_addr}, 0);
    idle(1'b0);
    chk("andn_stable", out_instr, 32'h4020F1B3);
    idle(1'b1);
    chk("addr_after_hs", {24'b0, out_addr}, 1);

    // clz then sext.h streaming
    cycle(1'b1, 4'd3, 5'd5, 5'd6, 5'd0, 1'b1, 1'b0);
    chk("clz_word", out_instr, 32'h60031293);
    cycle(1'b1, 4'd11, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    chk("sexth_word", out_instr, 32'h60511093);
    idle(1'b1);
    chk("stream_level", {29'b0, level}, 0);

    // fill with max while stalled, then drain
    repeat (4) cycle(1'b1, 4'd6, 5'd10, 5'd11, 5'd12, 1'b0, 1'b0);
    chk("full_in_ready", {31'b0, in_ready}, 0);
    chk("max_word", out_instr, 32'h0AC5E533);
    cycle(1'b1, 4'd6, 5'd10, 5'd11, 5'd12, 1'b0, 1'b0);
    repeat (5) idle(1'b1);

    // illegal op
    cycle(1'b1, 4'd13, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0);
    chk("illegal_pulse", {31'b0, err_illegal}, 1);
    chk("illegal_level", {29'b0, level}, 0);
    idle(1'b1);
    chk("illegal_single", {31'b0, err_illegal}, 0);

    // clr with a simultaneous push
    repeat (3) cycle(1'b1, 4'd7, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0);
    cycle(1'b1, 4'd1, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1);
    chk("clr_level", {29'b0, level}, 0);
    chk("clr_valid", {31'b0, out_valid}, 0);
    chk("clr_addr", {24'b0, out_addr}, 0);
    idle(1'b0);

    // async reset mid-stream
    repeat (3) cycle(1'b1, 4'd8, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0);
    cycle(1'b1, 4'd9, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_level", {29'b0, level}, 0);
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_addr", {24'b0, out_addr}, 0);
    mq.delete();
    m_addr = 0;
    m_err  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 5'($urandom),
            5'($urandom), 5'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 39) == 0));
    end
    repeat (6) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zbb_encoder.md
# zbb_encoder

Streaming instruction encoder for the Zbb subset: accepts an abstract operation (op code plus rd/rs1/rs2 register numbers) over a valid/ready handshake and emits the 32-bit RV32 Zbb instruction word. Each word is paired with an auto-incrementing word address, ready for writing into instruction memory. It is the producing end of the instruction fields that the Zbb execute unit decodes. It sits between a test/boot program source and the imem write port, buffering through a small FIFO.

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, ≥2.
- `ADDR_W`, 8 — width of the word-address counter.
- `BASE_ADDR`, 0 — counter value after reset/clear.

- `clk`  in  1  — clock, rising edge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `clr`  in  1  — synchronous flush: empties FIFO, reloads address.
- `in_valid`  in  1  — request present.
- `in_ready`  out  1  — request accepted this cycle when high with `in_valid`.
- `in_op`  in  4  — 0 andn, 1 orn, 2 xnor, 3 clz, 4 ctz, 5 cpop, 6 max, 7 maxu, 8 min, 9 minu, 10 sext.b, 11 sext.h; 12–15 illegal.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  — register numbers; `in_rs2` ignored for unary ops 3,4,5,10,11.
- `out_valid`  out  1  — instruction word available.
- `out_ready`  in  1  — consumer takes word when high with `out_valid`.
- `out_instr`  out  32  — encoded instruction.
- `out_addr`  out  ADDR_W  — word address for `out_instr`.
- `level`  out  $clog2(DEPTH)+1  — current FIFO occupancy.
- `err_illegal`  out  1  — one-cycle pulse, registered, on acceptance of an illegal op.

## Operation
- Encoding is combinational at the input; the FIFO stores finished 32-bit words.
- R-type ops (0,1,2,6–9): `{f7, rs2, rs1, f3, rd, 7'b0110011}`.
  - andn: f7 0100000, f3 111. orn: 0100000, 110. xnor: 0100000, 100.
  - max: 0000101, 110. maxu: 0000101, 111. min: 0000101, 100. minu: 0000101, 101.
- Unary ops (3,4,5,10,11): `{imm12, rs1, 3'b001, rd, 7'b0010011}`.
  - imm12: clz 0x600, ctz 0x601, cpop 0x602, sext.b 0x604, sext.h 0x605.
- Illegal op: handshake completes (`in_ready` honoured), nothing is pushed, `err_illegal` pulses the next cycle.
- `in_ready` = !full && !clr.
- Push and pop in the same cycle leave `level` unchanged. A push when full cannot occur.
- `out_addr` is the address of the FIFO head word. It increments by 1 on each output handshake and wraps modulo 2^ADDR_W with no flag.
- `clr` is highest priority: FIFO emptied, `out_addr` reloaded to BASE_ADDR, any same-cycle push and pop discarded, `err_illegal` not asserted for that cycle.
- Reset, async or mid-stream, behaves as `clr` but immediately: pending entries are lost.

## Timing
- Reset values: `out_valid` 0, `level` 0, `out_addr` BASE_ADDR, `err_illegal` 0, `in_ready` 1 once `rst` deasserts. `out_instr` is don't-care while `out_valid` is 0.
- Latency: an accepted legal op is visible on `out_*` the cycle after acceptance.
- Throughput: one word per cycle when `out_ready` is held high.
- `out_valid` never drops without a handshake or `clr`/`rst`. `out_instr` and `out_addr` are stable while `out_valid && !out_ready`.

## Configuration
- `ZBB_ENC_BYPASS_EN` defined: when the FIFO is empty and a legal op is accepted, the word is presented on `out_*` in the same cycle (combinational bypass). If `out_ready` is also high, the word is consumed without being stored, and `out_addr` still increments.
- Not defined: always registered, with 1-cycle latency.

## Test plan
- After reset, push andn rd=3 rs1=1 rs2=2 -> next cycle `out_instr`=0x4020F1B3, `out_addr`=0x00; handshake -> `out_addr`=0x01.
- Push clz rd=5 rs1=6 then sext.h rd=1 rs1=2 with `out_ready`=1 -> words 0x60031293, 0x60511093 on consecutive cycles; `level` returns to 0.
- Hold `out_ready`=0 and push max rd=10 rs1=11 rs2=12 four times (DEPTH=4) -> `in_ready`=0 after the 4th; release -> four words 0x0AC5E533 at addresses 0..3.
- Push op 13 -> accepted, `err_illegal` high for exactly one cycle, `level` unchanged, no output.
- With `ADDR_W`=2, stream 5 words -> addresses 0,1,2,3,0.
- Fill 3 entries, assert `clr` together with `in_valid` -> `level`=0, `out_valid`=0, `out_addr`=BASE_ADDR next cycle, and the pushed op is dropped. Repeat with async `rst` mid-stream -> same state immediately.
